// File: rtl/square_status_scheduler.sv
// -----------------------------------------------------------------------------
// square_status_scheduler
//
// Turns raw game-event requests (collision, heal pickup, shield pickup) into
// spaced one-cycle HURT / RECOVER pulses and a timed INVINCIBLE_ENABLE level
// for the square colour controller. The square's life level is tracked in
// lockstep with that controller, so every emitted pulse is a real change.
//
// Optional feature macro: SQUARE_REGEN_EN
//   When defined, LIFE auto-recovers by one every REGEN_TICKS ticks while the
//   square is IDLE or COOLDOWN and below full life.
//
// Ports
//   CLK                in   system clock, posedge
//   RESET              in   synchronous, active-high
//   HIT_REQ            in   collision request level (rising edge = event)
//   HEAL_REQ           in   heal pickup level (rising edge = event)
//   SHIELD_REQ         in   shield pickup level (rising edge = event)
//   PAUSE              in   freezes prescaler, timers and request acceptance
//   HURT               out  one-cycle pulse, life decremented
//   RECOVER            out  one-cycle pulse, life incremented
//   INVINCIBLE_ENABLE  out  high while the shield is active
//   LIFE[1:0]          out  2=strong, 1=ok, 0=weak
//   DEAD               out  sticky until RESET
// -----------------------------------------------------------------------------
module square_status_scheduler #(
    parameter int TICK_DIV       = 50000,
    parameter int INV_TICKS      = 3000,
    parameter int COOLDOWN_TICKS = 500,
    parameter int REGEN_TICKS    = 5000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       HIT_REQ,
    input  logic       HEAL_REQ,
    input  logic       SHIELD_REQ,
    input  logic       PAUSE,
    output logic       HURT,
    output logic       RECOVER,
    output logic       INVINCIBLE_ENABLE,
    output logic [1:0] LIFE,
    output logic       DEAD
);

    localparam int PW = $clog2(TICK_DIV);

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("TICK_DIV must be at least 2");
    end
    if ((INV_TICKS < 1) || (INV_TICKS > 65535)) begin : g_bad_inv
        $error("INV_TICKS out of range 1..65535");
    end
    if ((COOLDOWN_TICKS < 1) || (COOLDOWN_TICKS > 65535)) begin : g_bad_cool
        $error("COOLDOWN_TICKS out of range 1..65535");
    end
    if ((REGEN_TICKS < 1) || (REGEN_TICKS > 65535)) begin : g_bad_regen
        $error("REGEN_TICKS out of range 1..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COOLDOWN = 2'd1,
        S_SHIELDED = 2'd2,
        S_DEAD     = 2'd3
    } state_t;

    state_t        r_state,   w_state_nxt;
    logic [PW-1:0] r_presc,   w_presc_nxt;
    logic [15:0]   r_timer,   w_timer_nxt;
    logic [1:0]    r_life,    w_life_nxt;
    logic          r_pending, w_pending_nxt;
    logic          r_hurt,    w_hurt_nxt;
    logic          r_recover, w_recover_nxt;
    logic          r_hit_prev, r_heal_prev, r_shield_prev;
    logic          w_load;

`ifdef SQUARE_REGEN_EN
    logic [15:0]   r_regen,   w_regen_nxt;
    logic          w_regen_run;
    logic          w_regen_exp;
    logic          w_regen_fire;
`endif

    // Edge events; edges seen while paused are consumed but discarded.
    logic w_hit_ev, w_heal_ev, w_shield_ev, w_any_ev, w_tick;
    assign w_hit_ev    = HIT_REQ    & ~r_hit_prev    & ~PAUSE;
    assign w_heal_ev   = HEAL_REQ   & ~r_heal_prev   & ~PAUSE;
    assign w_shield_ev = SHIELD_REQ & ~r_shield_prev & ~PAUSE;
    assign w_any_ev    = w_hit_ev | w_heal_ev | w_shield_ev;
    assign w_tick      = (r_presc == PW'(TICK_DIV - 1)) & ~PAUSE;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= S_IDLE;
            r_presc       <= '0;
            r_timer       <= '0;
            r_life        <= 2'd2;
            r_pending     <= 1'b0;
            r_hurt        <= 1'b0;
            r_recover     <= 1'b0;
            r_hit_prev    <= 1'b0;
            r_heal_prev   <= 1'b0;
            r_shield_prev <= 1'b0;
`ifdef SQUARE_REGEN_EN
            r_regen       <= '0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_presc       <= w_presc_nxt;
            r_timer       <= w_timer_nxt;
            r_life        <= w_life_nxt;
            r_pending     <= w_pending_nxt;
            r_hurt        <= w_hurt_nxt;
            r_recover     <= w_recover_nxt;
            r_hit_prev    <= HIT_REQ;
            r_heal_prev   <= HEAL_REQ;
            r_shield_prev <= SHIELD_REQ;
`ifdef SQUARE_REGEN_EN
            r_regen       <= w_regen_nxt;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_life_nxt    = r_life;
        w_pending_nxt = r_pending;
        w_hurt_nxt    = 1'b0;
        w_recover_nxt = 1'b0;
        w_load        = 1'b0;

        if (!PAUSE) begin
            case (r_state)
                S_IDLE, S_COOLDOWN: begin
                    if (w_tick && (r_timer != 16'd0))
                        w_timer_nxt = r_timer - 16'd1;
                    if ((r_state == S_COOLDOWN) && w_tick && (r_timer == 16'd1))
                        w_state_nxt = S_IDLE;

                    // A heal deferred by the shield is serviced on the first
                    // IDLE cycle, one cycle after INVINCIBLE_ENABLE falls.
                    if ((r_state == S_IDLE) && r_pending) begin
                        w_pending_nxt = 1'b0;
                        if (r_life < 2'd2) begin
                            w_recover_nxt = 1'b1;
                            w_life_nxt    = r_life + 2'd1;
                        end
                    end else if (w_shield_ev) begin
                        w_state_nxt = S_SHIELDED;
                        w_timer_nxt = 16'(INV_TICKS);
                        w_load      = 1'b1;
                        if (w_heal_ev)
                            w_pending_nxt = 1'b1;
                    end else if (w_heal_ev) begin
                        if (r_life < 2'd2) begin
                            w_recover_nxt = 1'b1;
                            w_life_nxt    = r_life + 2'd1;
                        end
                    end else if (w_hit_ev && (r_state == S_IDLE)) begin
                        if (r_life != 2'd0) begin
                            w_hurt_nxt  = 1'b1;
                            w_life_nxt  = r_life - 2'd1;
                            w_timer_nxt = 16'(COOLDOWN_TICKS);
                            w_load      = 1'b1;
                            w_state_nxt = S_COOLDOWN;
                        end else begin
                            w_state_nxt = S_DEAD;
                        end
                    end
                end

                S_SHIELDED: begin
                    if (w_heal_ev)
                        w_pending_nxt = 1'b1;
                    if (w_shield_ev) begin
                        w_timer_nxt = 16'(INV_TICKS);
                        w_load      = 1'b1;
                    end else if (w_tick) begin
                        w_timer_nxt = r_timer - 16'd1;
                        if (r_timer == 16'd1)
                            w_state_nxt = S_IDLE;
                    end
                end

                default: ;
            endcase
        end

`ifdef SQUARE_REGEN_EN
        // Regen counts only below full life outside the shield; any event or
        // pending heal in its expiry cycle wins and the interval restarts.
        w_regen_nxt  = r_regen;
        w_regen_run  = !PAUSE && ((r_state == S_IDLE) || (r_state == S_COOLDOWN))
                       && (r_life < 2'd2);
        w_regen_exp  = w_regen_run && w_tick && (r_regen == 16'd1);
        w_regen_fire = w_regen_exp && !w_any_ev && !((r_state == S_IDLE) && r_pending);
        if (w_regen_run && w_tick && (r_regen != 16'd0))
            w_regen_nxt = r_regen - 16'd1;
        if (w_regen_fire) begin
            w_recover_nxt = 1'b1;
            w_life_nxt    = r_life + 2'd1;
        end
        if ((w_life_nxt != r_life) || (w_regen_exp && !w_regen_fire) ||
            ((w_state_nxt == S_SHIELDED) && (r_state != S_SHIELDED))) begin
            w_regen_nxt = 16'(REGEN_TICKS);
            w_load      = 1'b1;
        end
`endif

        // Prescaler restarts whenever any timer is loaded.
        if (w_load)
            w_presc_nxt = '0;
        else if (PAUSE)
            w_presc_nxt = r_presc;
        else if (r_presc == PW'(TICK_DIV - 1))
            w_presc_nxt = '0;
        else
            w_presc_nxt = r_presc + PW'(1);
    end

    // Output logic
    always_comb begin
        HURT              = r_hurt;
        RECOVER           = r_recover;
        INVINCIBLE_ENABLE = (r_state == S_SHIELDED);
        LIFE              = r_life;
        DEAD              = (r_state == S_DEAD);
    end

endmodule

// File: tb/tb_square_status_scheduler.sv
// -----------------------------------------------------------------------------
// tb_square_status_scheduler
//
// Directed bench for square_status_scheduler with TICK_DIV=4, INV_TICKS=5,
// COOLDOWN_TICKS=3, REGEN_TICKS=8. Inputs change 1 time unit after a rising
// edge; outputs are sampled at that same point, i.e. after the edge that
// registered them. Regen checks follow SQUARE_REGEN_EN.
// -----------------------------------------------------------------------------
module tb_square_status_scheduler;

    logic       CLK;
    logic       RESET;
    logic       HIT_REQ;
    logic       HEAL_REQ;
    logic       SHIELD_REQ;
    logic       PAUSE;
    logic       HURT;
    logic       RECOVER;
    logic       INVINCIBLE_ENABLE;
    logic [1:0] LIFE;
    logic       DEAD;

    int n_tests = 0;
    int n_fail  = 0;

    square_status_scheduler #(
        .TICK_DIV      (4),
        .INV_TICKS     (5),
        .COOLDOWN_TICKS(3),
        .REGEN_TICKS   (8)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .HIT_REQ          (HIT_REQ),
        .HEAL_REQ         (HEAL_REQ),
        .SHIELD_REQ       (SHIELD_REQ),
        .PAUSE            (PAUSE),
        .HURT             (HURT),
        .RECOVER          (RECOVER),
        .INVINCIBLE_ENABLE(INVINCIBLE_ENABLE),
        .LIFE             (LIFE),
        .DEAD             (DEAD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_inputs();
        HIT_REQ    = 1'b0;
        HEAL_REQ   = 1'b0;
        SHIELD_REQ = 1'b0;
        PAUSE      = 1'b0;
    endtask

    // Called right after the shield-entry edge S; counts cycles until
    // INVINCIBLE_ENABLE drops while issuing one-shot requests at offsets k.
    task automatic measure_shield(input int hit_at, input int shield_at,
                                  input int heal_at, input int pause_from,
                                  input int pause_len, output int cycles,
                                  output int hurts, output int recs);
        cycles = 0;
        hurts  = 0;
        recs   = 0;
        for (int k = 1; k <= 200; k++) begin
            HIT_REQ    = (k == hit_at);
            SHIELD_REQ = (k == shield_at);
            HEAL_REQ   = (k == heal_at);
            PAUSE      = (k >= pause_from) && (k < pause_from + pause_len);
            step();
            hurts  += int'(HURT);
            recs   += int'(RECOVER);
            cycles = k;
            if (!INVINCIBLE_ENABLE) break;
        end
        clear_inputs();
    endtask

    task automatic hit_once();
        HIT_REQ = 1'b1;
        step();
        HIT_REQ = 1'b0;
    endtask

    int cyc, hs, rs, cnt;

    initial begin
        clear_inputs();
        RESET = 1'b1;
        steps(2);
        RESET = 1'b0;

        // Reset state
        check("rst_hurt", int'(HURT), 0);
        check("rst_recover", int'(RECOVER), 0);
        check("rst_inv", int'(INVINCIBLE_ENABLE), 0);
        check("rst_life", int'(LIFE), 2);
        check("rst_dead", int'(DEAD), 0);

        // Hit, ignored hit inside cooldown, hit just after cooldown
        hit_once();                                   // edge N
        check("hit1_hurt", int'(HURT), 1);
        check("hit1_life", int'(LIFE), 1);
        step();                                       // N+1
        check("hit1_pulse_len", int'(HURT), 0);
        steps(4);                                     // N+5
        hit_once();                                   // N+6
        check("hit_cool_ignored", int'(HURT), 0);
        check("hit_cool_life", int'(LIFE), 1);
        steps(6);                                     // N+12
        hit_once();                                   // N+13
        check("hit2_hurt", int'(HURT), 1);
        check("hit2_life", int'(LIFE), 0);

        // Death at LIFE=0 and sticky behaviour
        steps(13);
        hit_once();
        check("dead_no_hurt", int'(HURT), 0);
        check("dead_flag", int'(DEAD), 1);
        check("dead_life", int'(LIFE), 0);
        step();
        HEAL_REQ = 1'b1;
        step();
        HEAL_REQ = 1'b0;
        check("dead_heal_ignored", int'(RECOVER), 0);
        check("dead_heal_life", int'(LIFE), 0);
        SHIELD_REQ = 1'b1;
        step();
        SHIELD_REQ = 1'b0;
        check("dead_shield_ignored", int'(INVINCIBLE_ENABLE), 0);
        check("dead_sticky", int'(DEAD), 1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("dead_rst_life", int'(LIFE), 2);
        check("dead_rst_flag", int'(DEAD), 0);
        step();

        // Shield duration with a hit inside
        SHIELD_REQ = 1'b1;
        step();
        check("shield_rise", int'(INVINCIBLE_ENABLE), 1);
        measure_shield(5, 0, 0, 0, 0, cyc, hs, rs);
        check("shield_len", cyc, 20);
        check("shield_hit_ignored", hs, 0);
        check("shield_life", int'(LIFE), 2);
        steps(3);

        // Shield extension at cycle 10
        SHIELD_REQ = 1'b1;
        step();
        measure_shield(0, 10, 0, 0, 0, cyc, hs, rs);
        check("shield_ext_len", cyc, 30);

        // Heal during shield is deferred until after the shield ends
        hit_once();
        check("pre_heal_life", int'(LIFE), 1);
        steps(13);
        SHIELD_REQ = 1'b1;
        step();
        measure_shield(0, 0, 3, 0, 0, cyc, hs, rs);
        check("heal_shield_len", cyc, 20);
        check("heal_no_rec_in_shield", rs, 0);
        step();
        check("heal_pending_rec", int'(RECOVER), 1);
        check("heal_pending_life", int'(LIFE), 2);
        step();
        check("heal_pending_len", int'(RECOVER), 0);

        // Simultaneous HIT+HEAL+SHIELD, then a 10-cycle pause mid-shield
        hit_once();
        steps(13);
        HIT_REQ    = 1'b1;
        HEAL_REQ   = 1'b1;
        SHIELD_REQ = 1'b1;
        step();
        clear_inputs();
        check("prio_inv", int'(INVINCIBLE_ENABLE), 1);
        check("prio_no_hurt", int'(HURT), 0);
        check("prio_no_rec", int'(RECOVER), 0);
        check("prio_life", int'(LIFE), 1);
        measure_shield(0, 0, 0, 5, 10, cyc, hs, rs);
        check("pause_shield_len", cyc, 30);
        check("pause_no_pulse", hs + rs, 0);
        step();
        check("prio_pending_rec", int'(RECOVER), 1);
        check("prio_pending_life", int'(LIFE), 2);
        step();

`ifdef SQUARE_REGEN_EN
        // Regen: one RECOVER 32 cycles after LIFE drops to 1, then quiet
        hit_once();
        check("regen_start_life", int'(LIFE), 1);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!RECOVER && cnt < 100);
        check("regen_latency", cnt, 32);
        check("regen_life", int'(LIFE), 2);
        hs = 0;
        rs = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            hs += int'(HURT);
            rs += int'(RECOVER);
        end
        check("regen_quiet", hs + rs, 0);
`else
        // No regen: LIFE stays at 1 without a heal
        hit_once();
        check("noregen_start_life", int'(LIFE), 1);
        rs = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            rs += int'(RECOVER);
        end
        check("noregen_no_rec", rs, 0);
        check("noregen_life", int'(LIFE), 1);
`endif

        // Reset mid-cooldown, with PAUSE held high
        hit_once();
        check("rst_cool_hurt", int'(HURT), 1);
        steps(2);
        RESET = 1'b1;
        PAUSE = 1'b1;
        step();
        check("rst_cool_life", int'(LIFE), 2);
        check("rst_cool_dead", int'(DEAD), 0);
        check("rst_cool_hurt0", int'(HURT), 0);
        check("rst_cool_inv", int'(INVINCIBLE_ENABLE), 0);
        RESET = 1'b0;
        PAUSE = 1'b0;
        hit_once();
        check("rst_cool_idle_hit", int'(HURT), 1);
        check("rst_cool_idle_life", int'(LIFE), 1);
        steps(13);

        // Reset mid-shield
        SHIELD_REQ = 1'b1;
        step();
        SHIELD_REQ = 1'b0;
        check("rst_shield_rise", int'(INVINCIBLE_ENABLE), 1);
        steps(3);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("rst_shield_inv", int'(INVINCIBLE_ENABLE), 0);
        check("rst_shield_life", int'(LIFE), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/square_status_scheduler.md
# square_status_scheduler

Event scheduler that sits between game-logic event sources (collision detector, heal pickups, shield pickups) and the square colour/state controller. Converts raw request edges into correctly spaced one-cycle HURT/RECOVER pulses and a timed INVINCIBLE_ENABLE level. Tracks the square's life level in lockstep with the colour controller so that every pulse it emits causes a real state change. Provides hit cooldown, shield duration and a sticky death flag.

## Interface
- TICK_DIV, 50000: CLK cycles per timer tick (1 ms at 50 MHz); ≥2.
- INV_TICKS, 3000: shield duration in ticks; 1..65535.
- COOLDOWN_TICKS, 500: hit-immunity window after an accepted hit, in ticks; 1..65535.
- REGEN_TICKS, 5000: auto-recover interval in ticks (regen build only); 1..65535.
- CLK  in  1  system clock; all logic on posedge.
- RESET  in  1  synchronous, active-high.
- HIT_REQ  in  1  collision request, level, synchronous to CLK; rising edge = one event.
- HEAL_REQ  in  1  heal pickup, rising edge = one event.
- SHIELD_REQ  in  1  shield pickup, rising edge = one event.
- PAUSE  in  1  high freezes prescaler, all timers and request acceptance.
- HURT  out  1  one-cycle pulse to colour controller.
- RECOVER  out  1  one-cycle pulse to colour controller.
- INVINCIBLE_ENABLE  out  1  level, high for the shield duration.
- LIFE  out  2  2=strong, 1=ok, 0=weak.
- DEAD  out  1  sticky until RESET.

## Operation
- Edge detect: each REQ registered into a prev flop; event = REQ & ~prev. prev flops update even while PAUSE=1; edges arriving during PAUSE are discarded.
- States: IDLE, COOLDOWN, SHIELDED, DEAD.
- Same-cycle priority: SHIELD > HEAL > HIT. Lower-priority events in that cycle are discarded, except HEAL under SHIELD which is made pending (below).
- IDLE: HIT → if LIFE>0: HURT pulse, LIFE−1, load cooldown, go COOLDOWN; if LIFE=0: no HURT, DEAD=1, go DEAD. HEAL → if LIFE<2: RECOVER pulse, LIFE+1; else ignored. SHIELD → INVINCIBLE_ENABLE=1, load shield timer, go SHIELDED.
- COOLDOWN: HIT ignored; HEAL and SHIELD as in IDLE (SHIELD abandons remaining cooldown). Timer expiry → IDLE.
- SHIELDED: HIT ignored. SHIELD reloads timer to INV_TICKS (extend). HEAL sets heal_pending (one-deep; further heals dropped). Expiry: INVINCIBLE_ENABLE=0 → IDLE; if heal_pending and LIFE<2, RECOVER pulse one cycle after INVINCIBLE_ENABLE falls, LIFE+1, pending cleared (cleared even if LIFE=2).
- DEAD: all requests ignored; HURT=RECOVER=INVINCIBLE_ENABLE=0; exit only via RESET.
- Never HURT and RECOVER in the same cycle; never a pulse while INVINCIBLE_ENABLE=1.

## Timing
- Reset values: HURT=0, RECOVER=0, INVINCIBLE_ENABLE=0, LIFE=2, DEAD=0, state IDLE, timers/prescaler/pending=0, prev flops=0.
- Latency: event sampled at posedge N → outputs change after posedge N (visible N..N+1); pulses exactly one cycle.
- Prescaler: mod-TICK_DIV counter, tick strobe on wrap; restarts at 0 whenever a timer is loaded. Timers 16-bit down-counters, decrement on tick, expiry when reaching 0.
- Shield: INVINCIBLE_ENABLE high for exactly INV_TICKS×TICK_DIV cycles (unpaused), restarted by extension.
- Cooldown: HIT ignored for COOLDOWN_TICKS×TICK_DIV cycles after the accepted hit cycle.
- PAUSE: counters hold value; outputs hold; resume continues mid-count.
- RESET mid-operation: all outputs to reset values on the next edge, regardless of state or PAUSE.

## Configuration
- SQUARE_REGEN_EN defined: regen timer runs in IDLE and COOLDOWN while LIFE<2; every REGEN_TICKS ticks emits RECOVER, LIFE+1. Timer reloads on any LIFE change or shield entry; held in SHIELDED/DEAD. A same-cycle HIT or HEAL event takes precedence and the regen pulse is dropped (timer reloads).
- Undefined: no regen logic; LIFE increases only via HEAL_REQ.

## Test plan (TICK_DIV=4, INV_TICKS=5, COOLDOWN_TICKS=3, REGEN_TICKS=8)
- Reset, HIT edge → HURT 1 cycle after edge, LIFE 2→1; second HIT 6 cycles later ignored; HIT at 13 cycles → HURT, LIFE=0.
- LIFE=0, HIT → no HURT, DEAD=1; later HEAL/SHIELD edges → no output change until RESET restores LIFE=2, DEAD=0.
- SHIELD edge → INVINCIBLE_ENABLE high exactly 20 cycles; HIT inside → ignored; SHIELD at cycle 10 → high total 30 cycles.
- LIFE=1, HEAL during shield → no RECOVER while shielded; RECOVER one cycle after INVINCIBLE_ENABLE falls, LIFE=2.
- HIT+HEAL+SHIELD same cycle → only INVINCIBLE_ENABLE rises, heal pending; PAUSE for 10 cycles mid-shield → shield ends 10 cycles later.
- SQUARE_REGEN_EN, LIFE=1, idle → RECOVER after 32 cycles, LIFE=2, no further pulses; RESET mid-cooldown → all outputs to reset values next edge.
